key_debounce_pulse: RTL and testbench

//   Conditions the raw active-low DE2 push-buttons (KEY[3:0]) before they reach
//   the CPU front panel (hal_1). key3 is "execute instruction" and key0 is
//   "show registers".
//   Per key, the block:
//   - synchronises the input to clk;
//   - debounces it with a stability counter;
//   - emits a clean held level, a one-cycle press strobe and a one-cycle

---
 rtl/key_debounce_pulse.sv | 123 ++++++++++++
 tb/tb_key_debounce_pulse.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse
//   Conditions raw active-low push-buttons for the CPU front panel. Each key
//   channel is handled on its own. The block synchronises the key to clk and
//   debounces it with a stability counter. It then produces a held level plus
//   one-cycle press and release strobes.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_n        raw buttons, 0 = pressed, asynchronous to clk
//   key_level    debounced state, 1 = pressed (registered)
//   key_press    one-cycle strobe on an accepted press (registered)
//   key_release  one-cycle strobe on an accepted release (registered)

module key_debounce_pulse #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    // Two-flop synchroniser; preset to released so reset never looks like a press.
    logic [NUM_KEYS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             press_d, release_d;
        logic             level_q, press_q, release_q;
        logic             s;

        assign s = sync2_q[k];

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!s) begin
                        state_d = StPressWait;
                        cnt_d   = '0;
                    end
                end
                StPressWait: begin
                    if (s) begin
                        state_d = StIdle;
                    end else if (cnt_q == CntLast) begin
                        state_d = StPressed;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (s) begin
                        state_d = StReleaseWait;
                        cnt_d   = '0;
                    end
                end
                StReleaseWait: begin
                    if (!s) begin
                        state_d = StPressed;
                    end else if (cnt_q == CntLast) begin
                        state_d   = StIdle;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                // Level tracks the next state so it rises on the same edge as the strobe.
                level_q   <= (state_d == StPressed) || (state_d == StReleaseWait);
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign key_level[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
module tb_key_debounce_pulse;

    localparam int NK = 4;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] key_level, key_press, key_release;

    int checks = 0;
    int failures = 0;

    key_debounce_pulse #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Reference model: a change is accepted once the synchronised key has
    // disagreed with the accepted level for DC+1 consecutive edges; any
    // agreeing sample restarts the run.
    logic [NK-1:0] m_sync1, m_sync2, m_level, m_press, m_rel;
    int            m_run [NK];

    always @(posedge clk or negedge rst_n) begin
        logic [NK-1:0] lvl, prs, rel;
        int            run [NK];
        if (!rst_n) begin
            m_sync1 <= '1;
            m_sync2 <= '1;
            m_level <= '0;
            m_press <= '0;
            m_rel   <= '0;
            for (int k = 0; k < NK; k++) m_run[k] <= 0;
        end else begin
            lvl = m_level;
            prs = '0;
            rel = '0;
            for (int k = 0; k < NK; k++) begin
                run[k] = m_run[k];
                if (!m_sync2[k] != lvl[k]) begin
                    run[k] = run[k] + 1;
                    if (run[k] == DC + 1) begin
                        lvl[k] = !m_sync2[k];
                        if (lvl[k]) prs[k] = 1'b1;
                        else        rel[k] = 1'b1;
                        run[k] = 0;
                    end
                end else begin
                    run[k] = 0;
                end
            end
            for (int k = 0; k < NK; k++) m_run[k] <= run[k];
            m_level <= lvl;
            m_press <= prs;
            m_rel   <= rel;
            m_sync2 <= m_sync1;
            m_sync1 <= key_n;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance past one rising edge and compare the DUT against the model.
    task automatic tick();
        @(posedge clk);
        #2;
        check("model_level", 32'(key_level), 32'(m_level));
        check("model_press", 32'(key_press), 32'(m_press));
        check("model_release", 32'(key_release), 32'(m_rel));
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [NK-1:0] acc;
        int            npress;

        // 1: reset with keys released
        key_n = '1;
        rst_n = 1'b0;
        #1;
        check("t1_reset_level", 32'(key_level), 0);
        check("t1_reset_press", 32'(key_press), 0);
        settle(2);
        rst_n = 1'b1;
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            acc = acc | key_level | key_press | key_release;
        end
        check("t1_idle_outputs", 32'(acc), 0);

        // 2: key3 press held 20 sampled edges, then released
        key_n[3] = 1'b0;
        for (int e = 0; e <= 30; e++) begin
            tick();
            if (e == 5) begin
                check("t2_press_early", 32'(key_press[3]), 0);
                check("t2_level_early", 32'(key_level[3]), 0);
            end
            if (e == 6) begin
                check("t2_press_edge6", 32'(key_press[3]), 1);
                check("t2_level_edge6", 32'(key_level[3]), 1);
            end
            if (e == 7) check("t2_press_single", 32'(key_press[3]), 0);
            if (e == 19) key_n[3] = 1'b1;
            if (e == 25) begin
                check("t2_release_early", 32'(key_release[3]), 0);
                check("t2_level_held", 32'(key_level[3]), 1);
            end
            if (e == 26) begin
                check("t2_release_edge26", 32'(key_release[3]), 1);
                check("t2_level_drop", 32'(key_level[3]), 0);
            end
            if (e == 27) check("t2_release_single", 32'(key_release[3]), 0);
        end
        settle(5);

        // 3: bounce low 2, high 1, then held low
        key_n[3] = 1'b0;
        npress = 0;
        acc = '0;
        for (int e = 0; e <= 15; e++) begin
            tick();
            if (e == 1) key_n[3] = 1'b1;
            if (e == 2) key_n[3] = 1'b0;
            if (e == 8) check("t3_press_early", 32'(key_press[3]), 0);
            if (e == 9) check("t3_press_edge9", 32'(key_press[3]), 1);
            if (key_press[3]) npress++;
            acc[3] = acc[3] | key_release[3];
        end
        check("t3_press_count", 32'(npress), 1);
        check("t3_no_release", 32'(acc[3]), 0);
        key_n[3] = 1'b1;
        settle(12);

        // 4: key0 glitch of 3 sampled cycles
        key_n[0] = 1'b0;
        acc = '0;
        settle(3);
        key_n[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            acc[0] = acc[0] | key_level[0] | key_press[0] | key_release[0];
        end
        check("t4_glitch_quiet", 32'(acc[0]), 0);

        // 5: keys 0 and 3 fall together
        key_n[0] = 1'b0;
        key_n[3] = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            tick();
            if (e == 6) check("t5_dual_press", 32'(key_press), 32'h9);
            if (e == 7) check("t5_dual_single", 32'(key_press), 0);
            if (e == 8) check("t5_level", 32'(key_level), 32'h9);
        end

        // 6: reset while key3 pressed (key0 released first)
        key_n[0] = 1'b1;
        settle(10);
        rst_n = 1'b0;
        #1;
        check("t6_reset_level", 32'(key_level), 0);
        check("t6_reset_press", 32'(key_press | key_release), 0);
        tick();
        check("t6_no_release", 32'(key_release), 0);
        rst_n = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            tick();
            if (e == 5) check("t6_press_early", 32'(key_press[3]), 0);
            if (e == 6) check("t6_press_edge6", 32'(key_press[3]), 1);
            if (e == 7) check("t6_press_single", 32'(key_press[3]), 0);
        end
        key_n = '1;
        settle(10);

        // Randomised bouncing on all keys, with occasional resets
        for (int i = 0; i < 4000; i++) begin
            tick();
            for (int k = 0; k < NK; k++)
                if ($urandom_range(7) == 0) key_n[k] = ~key_n[k];
            rst_n = ($urandom_range(499) != 0);
        end
        rst_n = 1'b1;
        key_n = '1;
        settle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
